// File: rtl/otbn_pq_bf_pipe_if.sv
// rtl/otbn_pq_bf_pipe_if.sv - handshake and data bundle of the PQ butterfly pipe
// Purpose: groups the operation input side (valid/ready, mode, operand vectors,
//   modulus parameters, lane enable, tag, flush) and the result side
//   (valid/ready, result vectors, lane enable, tag, illegal, busy).
// Modports: slave  - the butterfly pipe itself
//           master - the issuing / consuming agent
interface otbn_pq_bf_pipe_if #(
    parameter int PQLEN  = 32,
    parameter int NLANES = 8,
    parameter int TAGW   = 5
);
    localparam int WLEN = PQLEN * NLANES;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        mode_i;
    logic [WLEN-1:0]   op_a_i;
    logic [WLEN-1:0]   op_b_i;
    logic [WLEN-1:0]   twiddle_i;
    logic [PQLEN-1:0]  scale_i;
    logic [PQLEN-1:0]  prime_i;
    logic [PQLEN-1:0]  prime_dash_i;
    logic [NLANES-1:0] lane_en_i;
    logic [TAGW-1:0]   tag_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WLEN-1:0]   res0_o;
    logic [WLEN-1:0]   res1_o;
    logic [NLANES-1:0] lane_en_o;
    logic [TAGW-1:0]   tag_o;
    logic              illegal_o;
    logic              busy_o;

    modport slave (
        input  in_valid_i, mode_i, op_a_i, op_b_i, twiddle_i, scale_i, prime_i,
               prime_dash_i, lane_en_i, tag_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, res0_o, res1_o, lane_en_o, tag_o,
               illegal_o, busy_o
    );

    modport master (
        output in_valid_i, mode_i, op_a_i, op_b_i, twiddle_i, scale_i, prime_i,
               prime_dash_i, lane_en_i, tag_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, res0_o, res1_o, lane_en_o, tag_o,
               illegal_o, busy_o
    );
endinterface

// File: rtl/otbn_pq_bf_pipe.sv
// rtl/otbn_pq_bf_pipe.sv - 3-stage elastic multi-lane modular butterfly unit
// Purpose: CT/GS butterflies, modular add/sub, Montgomery multiply and scalar
//   scale over NLANES coefficient lanes, one vector per cycle, latency 3.
// Ports: clk_i, rst_ni (async active-low) and the slave side of
//   otbn_pq_bf_pipe_if: operation in (valid/ready, mode, operands, twiddles,
//   scale, prime, prime_dash, lane enable, tag, flush), result out
//   (valid/ready, res0/res1, lane enable, tag, illegal) and busy.
// Stages: S1 pre-arith (GS difference, multiplier operand steering),
//   S2 Montgomery multiply, S3 post-arith and result muxing (drives outputs).
module otbn_pq_bf_pipe #(
    parameter int PQLEN  = 32,
    parameter int NLANES = 8,
    parameter int LOG_R  = 32,
    parameter int TAGW   = 5
) (
    input logic              clk_i,
    input logic              rst_ni,
    otbn_pq_bf_pipe_if.slave bus
);
    typedef logic [NLANES-1:0][PQLEN-1:0] vec_t;

    localparam logic [2:0] MODE_CT    = 3'd0;
    localparam logic [2:0] MODE_GS    = 3'd1;
    localparam logic [2:0] MODE_ADD   = 3'd2;
    localparam logic [2:0] MODE_SUB   = 3'd3;
    localparam logic [2:0] MODE_MUL   = 3'd4;
    localparam logic [2:0] MODE_SCALE = 3'd5;

    function automatic logic [PQLEN-1:0] mod_add(input logic [PQLEN-1:0] a,
                                                 input logic [PQLEN-1:0] b,
                                                 input logic [PQLEN-1:0] q);
        logic [PQLEN:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[PQLEN-1:0];
    endfunction

    // a - b wraps in PQLEN bits, so adding q back lands exactly on a - b + q.
    function automatic logic [PQLEN-1:0] mod_sub(input logic [PQLEN-1:0] a,
                                                 input logic [PQLEN-1:0] b,
                                                 input logic [PQLEN-1:0] q);
        return (a >= b) ? (a - b) : (a - b + q);
    endfunction

    // REDC: m = (t mod R) * q' mod R makes t + m*q divisible by R; the
    // quotient is below 2q, so one conditional subtract fully reduces it.
    function automatic logic [PQLEN-1:0] mont_mul(input logic [PQLEN-1:0] x,
                                                  input logic [PQLEN-1:0] y,
                                                  input logic [PQLEN-1:0] q,
                                                  input logic [PQLEN-1:0] qd);
        logic [2*PQLEN-1:0] t;
        logic [LOG_R-1:0]   m;
        logic [2*PQLEN:0]   u;
        logic [PQLEN:0]     red;
        t   = {{PQLEN{1'b0}}, x} * {{PQLEN{1'b0}}, y};
        m   = t[LOG_R-1:0] * qd[LOG_R-1:0];
        u   = {1'b0, t} + (2*PQLEN+1)'(m) * (2*PQLEN+1)'(q);
        red = (PQLEN+1)'(u >> LOG_R);
        if (red >= {1'b0, q}) red = red - {1'b0, q};
        return red[PQLEN-1:0];
    endfunction

    // Stage registers
    logic              s1_valid;
    vec_t              s1_a, s1_b, s1_x, s1_y;
    logic [2:0]        s1_mode;
    logic [NLANES-1:0] s1_lane_en;
    logic [TAGW-1:0]   s1_tag;
    logic [PQLEN-1:0]  s1_prime, s1_prime_dash;

    logic              s2_valid;
    vec_t              s2_a, s2_b, s2_prod;
    logic [2:0]        s2_mode;
    logic [NLANES-1:0] s2_lane_en;
    logic [TAGW-1:0]   s2_tag;
    logic [PQLEN-1:0]  s2_prime;

    logic              s3_valid;
    vec_t              s3_res0, s3_res1;
    logic [NLANES-1:0] s3_lane_en;
    logic [TAGW-1:0]   s3_tag;
    logic              s3_illegal;

    // Stage k may load when it is empty or its content moves on this cycle.
    logic s1_en, s2_en, s3_en, in_fire;
    assign s3_en   = !s3_valid || bus.out_ready_i;
    assign s2_en   = !s2_valid || s3_en;
    assign s1_en   = !s1_valid || s2_en;
    assign in_fire = bus.in_valid_i && bus.in_ready_o;

    assign bus.in_ready_o  = s1_en && !bus.flush_i;
    assign bus.busy_o      = s1_valid | s2_valid | s3_valid;
    assign bus.out_valid_o = s3_valid;
    assign bus.res0_o      = s3_res0;
    assign bus.res1_o      = s3_res1;
    assign bus.lane_en_o   = s3_lane_en;
    assign bus.tag_o       = s3_tag;
    assign bus.illegal_o   = s3_illegal;

    // S1 input: multiplier operand steering. ADD/SUB/illegal feed zeros so the
    // multiplier array stays quiet when its product is not used.
    vec_t s1_x_d, s1_y_d;
    always_comb begin
        s1_x_d = '0;
        s1_y_d = '0;
        for (int i = 0; i < NLANES; i++) begin
            case (bus.mode_i)
                MODE_CT: begin
                    s1_x_d[i] = bus.op_b_i[PQLEN*i +: PQLEN];
                    s1_y_d[i] = bus.twiddle_i[PQLEN*i +: PQLEN];
                end
                MODE_GS: begin
                    s1_x_d[i] = mod_sub(bus.op_a_i[PQLEN*i +: PQLEN],
                                        bus.op_b_i[PQLEN*i +: PQLEN], bus.prime_i);
                    s1_y_d[i] = bus.twiddle_i[PQLEN*i +: PQLEN];
                end
                MODE_MUL: begin
                    s1_x_d[i] = bus.op_a_i[PQLEN*i +: PQLEN];
                    s1_y_d[i] = bus.op_b_i[PQLEN*i +: PQLEN];
                end
                MODE_SCALE: begin
                    s1_x_d[i] = bus.op_a_i[PQLEN*i +: PQLEN];
                    s1_y_d[i] = bus.scale_i;
                end
                default: ;
            endcase
        end
    end

    // S2 input: per-lane Montgomery products
    vec_t s2_prod_d;
    always_comb begin
        s2_prod_d = '0;
        for (int i = 0; i < NLANES; i++) begin
            s2_prod_d[i] = mont_mul(s1_x[i], s1_y[i], s1_prime, s1_prime_dash);
        end
    end

    // S3 input: final arithmetic; disabled lanes and illegal modes give zero
    vec_t s3_res0_d, s3_res1_d;
    logic s3_illegal_d;
    always_comb begin
        s3_res0_d    = '0;
        s3_res1_d    = '0;
        s3_illegal_d = (s2_mode > MODE_SCALE);
        for (int i = 0; i < NLANES; i++) begin
            if (s2_lane_en[i]) begin
                case (s2_mode)
                    MODE_CT: begin
                        s3_res0_d[i] = mod_add(s2_a[i], s2_prod[i], s2_prime);
                        s3_res1_d[i] = mod_sub(s2_a[i], s2_prod[i], s2_prime);
                    end
                    MODE_GS: begin
                        s3_res0_d[i] = mod_add(s2_a[i], s2_b[i], s2_prime);
                        s3_res1_d[i] = s2_prod[i];
                    end
                    MODE_ADD:   s3_res0_d[i] = mod_add(s2_a[i], s2_b[i], s2_prime);
                    MODE_SUB:   s3_res0_d[i] = mod_sub(s2_a[i], s2_b[i], s2_prime);
                    MODE_MUL:   s3_res0_d[i] = s2_prod[i];
                    MODE_SCALE: s3_res0_d[i] = s2_prod[i];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid      <= 1'b0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_x          <= '0;
            s1_y          <= '0;
            s1_mode       <= '0;
            s1_lane_en    <= '0;
            s1_tag        <= '0;
            s1_prime      <= '0;
            s1_prime_dash <= '0;
        end else begin
            if (bus.flush_i) begin
                s1_valid <= 1'b0;
            end else if (s1_en) begin
                s1_valid <= bus.in_valid_i;
            end
            if (in_fire) begin
                s1_a          <= bus.op_a_i;
                s1_b          <= bus.op_b_i;
                s1_x          <= s1_x_d;
                s1_y          <= s1_y_d;
                s1_mode       <= bus.mode_i;
                s1_lane_en    <= bus.lane_en_i;
                s1_tag        <= bus.tag_i;
                s1_prime      <= bus.prime_i;
                s1_prime_dash <= bus.prime_dash_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid   <= 1'b0;
            s2_a       <= '0;
            s2_b       <= '0;
            s2_prod    <= '0;
            s2_mode    <= '0;
            s2_lane_en <= '0;
            s2_tag     <= '0;
            s2_prime   <= '0;
        end else begin
            if (bus.flush_i) begin
                s2_valid <= 1'b0;
            end else if (s2_en) begin
                s2_valid <= s1_valid;
            end
            if (s2_en && s1_valid) begin
                s2_a       <= s1_a;
                s2_b       <= s1_b;
                s2_prod    <= s2_prod_d;
                s2_mode    <= s1_mode;
                s2_lane_en <= s1_lane_en;
                s2_tag     <= s1_tag;
                s2_prime   <= s1_prime;
            end
        end
    end

    // S3 data only changes when S3 advances, so outputs hold under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s3_valid   <= 1'b0;
            s3_res0    <= '0;
            s3_res1    <= '0;
            s3_lane_en <= '0;
            s3_tag     <= '0;
            s3_illegal <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                s3_valid <= 1'b0;
            end else if (s3_en) begin
                s3_valid <= s2_valid;
            end
            if (s3_en && s2_valid) begin
                s3_res0    <= s3_res0_d;
                s3_res1    <= s3_res1_d;
                s3_lane_en <= s2_lane_en;
                s3_tag     <= s2_tag;
                s3_illegal <= s3_illegal_d;
            end
        end
    end
endmodule
